// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locking arbiter sharing one uart_tx among cli_* valid/ready producers (tx_data/tx_start/tx_busy to uart_tx; grant/locked/ack_err status)
module uart_tx_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_BITS   = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CLIENTS-1:0]           cli_valid,
  input  logic [NUM_CLIENTS*DATA_BITS-1:0] cli_data,
  input  logic [NUM_CLIENTS-1:0]           cli_last,
  output logic [NUM_CLIENTS-1:0]           cli_ready,
  output logic [DATA_BITS-1:0]             tx_data,
  output logic                             tx_start,
  input  logic                             tx_busy,
  output logic [NUM_CLIENTS-1:0]           grant,
  output logic                             locked,
  output logic                             ack_err
);
  localparam int PW = $clog2(NUM_CLIENTS);
  localparam int CW = $clog2(ACK_TIMEOUT);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, own_q, own_d, pick, idx, nxt;
  logic [PW:0] sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic [NUM_CLIENTS-1:0] grant_q, grant_d;
  logic tx_start_q, tx_start_d, locked_q, locked_d, last_q, last_d, found, accept, timeout;
  always_comb begin
    found = locked_q & cli_valid[own_q];
    pick = own_q;
    sum = '0;
    idx = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      idx = (sum >= (PW+1)'(NUM_CLIENTS)) ? PW'(sum - (PW+1)'(NUM_CLIENTS)) : sum[PW-1:0];
      if (!locked_q && cli_valid[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
  end
  assign accept = reset && state_q == IDLE && found;
  assign cli_ready = accept ? (NUM_CLIENTS'(1) << pick) : '0;
  assign nxt = (own_q == PW'(NUM_CLIENTS - 1)) ? '0 : own_q + PW'(1);
  assign timeout = state_q == WAIT_BUSY && !tx_busy && cnt_q == CW'(ACK_TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    own_d = own_q;
    cnt_d = cnt_q;
    tx_data_d = tx_data_q;
    grant_d = grant_q;
    tx_start_d = 1'b0;
    locked_d = locked_q;
    last_d = last_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = LAUNCH;
        tx_data_d = cli_data[int'(pick)*DATA_BITS +: DATA_BITS];
        grant_d = cli_ready;
        own_d = pick;
        last_d = cli_last[pick];
        tx_start_d = 1'b1;
      end
      LAUNCH: begin
        cnt_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: if (tx_busy) state_d = WAIT_DONE;
      else if (timeout) begin
        state_d = IDLE;
        locked_d = 1'b0;
        grant_d = '0;
        ptr_d = nxt;
      end
      else cnt_d = cnt_q + CW'(1);
      WAIT_DONE: if (!tx_busy) begin
        state_d = IDLE;
        locked_d = !last_q;
        grant_d = last_q ? '0 : grant_q;
        ptr_d = last_q ? nxt : ptr_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      own_q <= '0;
      cnt_q <= '0;
      tx_data_q <= '0;
      grant_q <= '0;
      tx_start_q <= 1'b0;
      locked_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      own_q <= own_d;
      cnt_q <= cnt_d;
      tx_data_q <= tx_data_d;
      grant_q <= grant_d;
      tx_start_q <= tx_start_d;
      locked_q <= locked_d;
      last_q <= last_d;
    end
  assign tx_data = tx_data_q;
  assign tx_start = tx_start_q;
  assign grant = grant_q;
  assign locked = locked_q;
  assign ack_err = timeout;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter with a 3-cycle uart_tx busy model
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int FRAME = 3;
  typedef struct packed {logic [1:0] c; logic last; logic [7:0] d;} ent_t;
  logic clk, reset, tx_start, tx_busy, locked, ack_err, dead, seen_lock;
  logic [N-1:0] cli_valid, cli_last, cli_ready, grant, drv_v, drv_l;
  logic [N*W-1:0] cli_data, drv_d;
  logic [W-1:0] tx_data;
  ent_t pend[$];
  int acc_c[$];
  logic [7:0] tx_log[$];
  int checks = 0;
  int errors = 0;
  int overlap = 0;
  int acks = 0;
  int bad_ready = 0;
  int rem = 0;
  uart_tx_arbiter #(.NUM_CLIENTS(N), .DATA_BITS(W), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .cli_valid(cli_valid), .cli_data(cli_data), .cli_last(cli_last),
    .cli_ready(cli_ready), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant(grant), .locked(locked), .ack_err(ack_err)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  initial begin
    cli_valid = '0;
    cli_last = '0;
    cli_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_start && tx_busy) overlap++;
      drv_v = '0;
      drv_l = '0;
      drv_d = '0;
      for (int k = pend.size() - 1; k >= 0; k--) begin
        drv_v[pend[k].c] = 1'b1;
        drv_l[pend[k].c] = pend[k].last;
        drv_d[int'(pend[k].c)*W +: W] = pend[k].d;
      end
      cli_valid = drv_v;
      cli_last = drv_l;
      cli_data = drv_d;
    end
  end
  initial begin
    tx_busy = 0;
    dead = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!reset) begin
        tx_busy = 0;
        rem = 0;
      end else if (tx_start && !dead) begin
        tx_busy = 1;
        rem = FRAME;
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) tx_busy = 0;
      end
    end
  end
  initial begin
    seen_lock = 0;
    forever begin
      @(negedge clk);
      if (ack_err) acks++;
      if (locked && grant == 4'b0010) seen_lock = 1;
      if (locked && cli_ready[0]) bad_ready++;
      if (tx_start) tx_log.push_back(tx_data);
      for (int i = 0; i < N; i++)
        if (cli_valid[i] && cli_ready[i]) begin
          acc_c.push_back(i);
          for (int k = 0; k < pend.size(); k++)
            if (int'(pend[k].c) == i) begin
              pend.delete(k);
              break;
            end
        end
    end
  end
  task automatic step();
    @(posedge clk);
    #3;
  endtask
  task automatic push(input int c, input logic last, input logic [7:0] d);
    ent_t e;
    e.c = 2'(c);
    e.last = last;
    e.d = d;
    pend.push_back(e);
  endtask
  task automatic clear_logs();
    acc_c.delete();
    tx_log.delete();
    acks = 0;
    seen_lock = 0;
    bad_ready = 0;
  endtask
  task automatic do_reset();
    reset = 0;
    pend.delete();
    step();
    step();
    reset = 1;
    step();
    clear_logs();
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (n < 400 && !(pend.size() == 0 && grant == '0 && !tx_busy && !tx_start)) begin
      step();
      n++;
    end
    check({tag, "_budget"}, 32'(n < 400), 1);
  endtask
  task automatic verify(input string tag, input int n, input logic [31:0] ec, input logic [63:0] ed);
    check({tag, "_nacc"}, acc_c.size(), n);
    check({tag, "_ntx"}, tx_log.size(), n);
    for (int k = 0; k < n && k < acc_c.size() && k < tx_log.size(); k++) begin
      check($sformatf("%s_client%0d", tag, k), acc_c[k], 32'(ec[k*4 +: 4]));
      check($sformatf("%s_data%0d", tag, k), 32'(tx_log[k]), 32'(ed[k*8 +: 8]));
    end
  endtask
  initial begin
    int n;
    reset = 0;
    for (int c = 0; c < N; c++) push(c, 1, 8'h99);
    step();
    step();
    check("rst_ready", cli_ready, 0);
    check("rst_grant", grant, 0);
    check("rst_locked", locked, 0);
    check("rst_start", tx_start, 0);
    check("rst_data", tx_data, 0);
    check("rst_ackerr", ack_err, 0);
    pend.delete();
    step();
    reset = 1;
    step();
    clear_logs();
    push(2, 1, 8'hA5);
    step();
    check("t1_ready", cli_ready, 4'b0100);
    check("t1_grant_idle", grant, 0);
    check("t1_start_idle", tx_start, 0);
    step();
    check("t1_start", tx_start, 1);
    check("t1_data", tx_data, 8'hA5);
    check("t1_grant", grant, 4'b0100);
    check("t1_ready_launch", cli_ready, 0);
    step();
    check("t1_pulse", tx_start, 0);
    check("t1_grant_hold", grant, 4'b0100);
    wait_done("t1");
    check("t1_locked", locked, 0);
    check("t1_data_stable", tx_data, 8'hA5);
    verify("t1", 1, 32'h2, 64'hA5);
    do_reset();
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < N; c++) push(c, 1, 8'((c + 1) * 16 + b));
    wait_done("t2");
    verify("t2", 8, 32'h3210_3210, 64'h41312111_40302010);
    do_reset();
    push(0, 1, 8'h0A);
    wait_done("t3_pre");
    clear_logs();
    push(1, 0, 8'h1A);
    push(1, 0, 8'h1B);
    push(1, 1, 8'h1C);
    push(0, 1, 8'h0C);
    wait_done("t3");
    check("t3_seen_lock", seen_lock, 1);
    check("t3_no_ready_other", bad_ready, 0);
    check("t3_unlocked", locked, 0);
    verify("t3", 4, 32'h0111, 64'h0C1C1B1A);
    do_reset();
    dead = 1;
    push(0, 1, 8'h40);
    push(1, 1, 8'h41);
    step();
    check("t4_ready", cli_ready, 4'b0001);
    n = 0;
    while (n < 5 && !tx_start) begin
      step();
      n++;
    end
    check("t4_launch", tx_start, 1);
    n = 0;
    while (n < 30 && !ack_err) begin
      step();
      n++;
    end
    check("t4_ack_latency", n, 16);
    check("t4_grant_at_err", grant, 4'b0001);
    dead = 0;
    step();
    check("t4_ack_one_cycle", ack_err, 0);
    check("t4_grant_cleared", grant, 0);
    check("t4_lock_cleared", locked, 0);
    check("t4_next_ready", cli_ready, 4'b0010);
    wait_done("t4");
    check("t4_ack_count", acks, 1);
    verify("t4", 2, 32'h10, 64'h4140);
    do_reset();
    push(2, 0, 8'h51);
    push(2, 1, 8'h52);
    n = 0;
    while (n < 50 && !locked) begin
      step();
      n++;
    end
    check("t5_locked", locked, 1);
    n = 0;
    while (n < 10 && !tx_start) begin
      step();
      n++;
    end
    check("t5_byte2", tx_data, 8'h52);
    step();
    step();
    check("t5_pre_grant", grant, 4'b0100);
    check("t5_pre_busy", tx_busy, 1);
    reset = 0;
    #1;
    check("t5_grant", grant, 0);
    check("t5_locked_clr", locked, 0);
    check("t5_data", tx_data, 0);
    check("t5_start", tx_start, 0);
    check("t5_ackerr", ack_err, 0);
    clear_logs();
    pend.delete();
    push(3, 1, 8'h63);
    push(0, 1, 8'h60);
    step();
    step();
    check("t5_ready_in_reset", cli_ready, 0);
    reset = 1;
    wait_done("t5");
    verify("t5", 2, 32'h30, 64'h6360);
    push(2, 1, 8'h72);
    wait_done("t6_pre");
    clear_logs();
    push(3, 1, 8'h73);
    step();
    check("t6_ready", cli_ready, 4'b1000);
    wait_done("t6a");
    verify("t6a", 1, 32'h3, 64'h73);
    clear_logs();
    push(3, 1, 8'h74);
    push(0, 1, 8'h70);
    wait_done("t6b");
    verify("t6b", 2, 32'h30, 64'h7470);
    check("overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
